// File: rtl/m72_shift_pkg.sv
// Shared definitions for the tile/sprite shifter path and its deserializer.
// Holds the default word width, a bit-reversal helper and a lane slice helper.
package m72_shift_pkg;

    localparam int unsigned WORD_W = 8;
    // Widest word the bit-reversal helper handles.
    localparam int unsigned MAX_W  = 64;

    // Reverse the low w bits of x; bits at and above w come back as zero.
    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x,
                                                input int unsigned     w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r[i] = x[w-1-i];
            end
        end
        return r;
    endfunction

    // LSB position of lane p in a flat PLANES*w vector.
    function automatic int unsigned lane_lsb(input int unsigned p, input int unsigned w);
        return p * w;
    endfunction

endpackage

// File: rtl/deser_lane.sv
// One serial lane: W-bit MSB-first shift register with synchronous clear.
// word_next is the word that would be complete if this cycle's bit were the last.
module deser_lane #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         shift_en,
    input  logic         sync_n,
    input  logic         ser_in,
    output logic [W-1:0] word_next
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    assign word_next = {sr_q[W-2:0], ser_in};

    // Next shift state: sync restarts the word, taking this cycle's bit as bit 0 if shifting.
    always_comb begin
        sr_d = sr_q;
        if (!sync_n) begin
            sr_d = shift_en ? {{(W-1){1'b0}}, ser_in} : '0;
        end else if (shift_en) begin
            sr_d = word_next;
        end
    end

    // Shift register state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/deserializer_ls164.sv
// Serial-to-parallel receiver: PLANES MSB-first lanes into W-bit words, presented
// through a one-entry valid/ready holding register with a sticky overrun flag.
// Optional: define DESER_FLIP_OUT_EN to add par_out_rev (per-lane bit-reversed par_out).
module deserializer_ls164
    import m72_shift_pkg::*;
#(
    parameter int unsigned W      = WORD_W,
    parameter int unsigned PLANES = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  shift_en,
    input  logic                  sync_n,
    input  logic [PLANES-1:0]     ser_in,
    input  logic                  par_ready,
    input  logic                  clr_ovr,
    output logic [PLANES*W-1:0]   par_out,
    output logic                  par_valid,
    output logic                  overrun,
    output logic [$clog2(W)-1:0]  bit_cnt
`ifdef DESER_FLIP_OUT_EN
    ,
    output logic [PLANES*W-1:0]   par_out_rev
`endif
);

    localparam int unsigned CntW = $clog2(W);

    logic [PLANES*W-1:0] word_next;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [PLANES*W-1:0] hold_q, hold_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                complete;
    logic                consume;

    for (genvar p = 0; p < PLANES; p++) begin : g_lane
        deser_lane #(
            .W(W)
        ) u_lane (
            .clock     (clock),
            .reset_n   (reset_n),
            .shift_en  (shift_en),
            .sync_n    (sync_n),
            .ser_in    (ser_in[p]),
            .word_next (word_next[p*W +: W])
        );
    end

    // A sync cycle never completes a word, even at the last bit position.
    assign complete = shift_en && sync_n && (cnt_q == CntW'(W - 1));
    assign consume  = valid_q && par_ready;

    // Bit counter, hold register, handshake and overrun next-state.
    always_comb begin
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        ovr_d   = clr_ovr ? 1'b0 : ovr_q;

        if (!sync_n) begin
            cnt_d = shift_en ? CntW'(1) : '0;
        end else if (shift_en) begin
            cnt_d = complete ? '0 : cnt_q + CntW'(1);
        end

        if (complete) begin
            if (!valid_q || consume) begin
                hold_d  = word_next;
                valid_d = 1'b1;
            end else begin
                // Drop the new word; set beats a same-cycle clear.
                ovr_d = 1'b1;
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    // Control and hold state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign par_out   = hold_q;
    assign par_valid = valid_q;
    assign overrun   = ovr_q;
    assign bit_cnt   = cnt_q;

`ifdef DESER_FLIP_OUT_EN
    logic [MAX_W-1:0] rev_word;

    // LSB-first view of each lane of the held word.
    always_comb begin
        par_out_rev = '0;
        rev_word    = '0;
        for (int unsigned p = 0; p < PLANES; p++) begin
            rev_word = bitrev(MAX_W'(hold_q[lane_lsb(p, W) +: W]), W);
            par_out_rev[lane_lsb(p, W) +: W] = rev_word[W-1:0];
        end
    end
`endif

endmodule
